baccarat_round_sched: RTL and testbench

Round scheduler for the baccarat datapath: sequences one full hand per `start` request: two cards each, the third-card rules for player and banker, then winner resolution. A request/valid handshake paces each deal to the shared card source. Per-card load strobes go to the player/dealer hand registers, and saturating win/tie/round tallies are kept across rounds. Sits between the push-button/clock front end and the card/score datapath.

---
 rtl/baccarat_round_sched_if.sv | 30 +++
 rtl/baccarat_round_sched.sv | 163 ++++++++++++++++
 tb/tb_baccarat_round_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/baccarat_round_sched_if.sv
// Card-source handshake and datapath hand-register controls for the round scheduler.
// The master side is the scheduler; the slave side is the card/score datapath.
interface baccarat_round_sched_if;
  logic       card_req;
  logic       card_valid;
  logic       clear_hands;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;

  modport master (
    output card_req, clear_hands,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    input  card_valid, pscore, dscore, pcard3
  );

  modport slave (
    input  card_req, clear_hands,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    output card_valid, pscore, dscore, pcard3
  );
endinterface

// File: rtl/baccarat_round_sched.sv
// Baccarat round scheduler: deals one hand per start request, applies the
// third-card rules, resolves the winner and keeps saturating tallies.
//
// state  | meaning
// IDLE   | waiting for start after reset
// CLR    | clear datapath hand registers
// P1     | deal player card 1
// D1     | deal dealer card 1
// P2     | deal player card 2
// D2     | deal dealer card 2
// EVAL   | naturals / player third-card decision
// P3     | deal player card 3
// EVAL3  | banker third-card decision using pcard3
// D3     | deal dealer card 3
// RESULT | compare scores, update lights and tallies on exit
// DONE   | result held, waiting for start
module baccarat_round_sched #(
  parameter int TW = 4
) (
  input  logic                  slow_clock,
  input  logic                  resetb,
  input  logic                  start,
  baccarat_round_sched_if.master card,
  output logic                  player_win_light,
  output logic                  dealer_win_light,
  output logic [TW-1:0]         player_wins,
  output logic [TW-1:0]         dealer_wins,
  output logic [TW-1:0]         ties,
  output logic [TW-1:0]         rounds,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_P1, S_D1, S_P2, S_D2, S_EVAL,
    S_P3, S_EVAL3, S_D3, S_RESULT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   banker_draw;
  logic   restart;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    banker_draw = 1'b0;
    case (card.dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (card.pcard3 != 4'd8);
      4'd4:             banker_draw = (card.pcard3 >= 4'd2) && (card.pcard3 <= 4'd7);
      4'd5:             banker_draw = (card.pcard3 >= 4'd4) && (card.pcard3 <= 4'd7);
      4'd6:             banker_draw = (card.pcard3 >= 4'd6) && (card.pcard3 <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  assign restart = resetb && start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge slow_clock) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    card.card_req    = 1'b0;
    card.clear_hands = 1'b0;
    card.load_pcard1 = 1'b0;
    card.load_pcard2 = 1'b0;
    card.load_pcard3 = 1'b0;
    card.load_dcard1 = 1'b0;
    card.load_dcard2 = 1'b0;
    card.load_dcard3 = 1'b0;
    busy             = 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        busy = 1'b0;
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        card.clear_hands = 1'b1;
        state_d          = S_P1;
      end
      S_P1: begin
        card.card_req    = 1'b1;
        card.load_pcard1 = card.card_valid;
        if (card.card_valid) state_d = S_D1;
      end
      S_D1: begin
        card.card_req    = 1'b1;
        card.load_dcard1 = card.card_valid;
        if (card.card_valid) state_d = S_P2;
      end
      S_P2: begin
        card.card_req    = 1'b1;
        card.load_pcard2 = card.card_valid;
        if (card.card_valid) state_d = S_D2;
      end
      S_D2: begin
        card.card_req    = 1'b1;
        card.load_dcard2 = card.card_valid;
        if (card.card_valid) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (card.pscore >= 4'd8 || card.dscore >= 4'd8) state_d = S_RESULT;
        else if (card.pscore <= 4'd5)                    state_d = S_P3;
        else if (card.dscore <= 4'd5)                    state_d = S_D3;
        else                                             state_d = S_RESULT;
      end
      S_P3: begin
        card.card_req    = 1'b1;
        card.load_pcard3 = card.card_valid;
        if (card.card_valid) state_d = S_EVAL3;
      end
      S_EVAL3: state_d = banker_draw ? S_D3 : S_RESULT;
      S_D3: begin
        card.card_req    = 1'b1;
        card.load_dcard3 = card.card_valid;
        if (card.card_valid) state_d = S_RESULT;
      end
      S_RESULT: state_d = S_DONE;
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Strobes are suppressed while reset is asserted so an aborted round never loads a card.
    if (!resetb) begin
      card.card_req    = 1'b0;
      card.clear_hands = 1'b0;
      card.load_pcard1 = 1'b0;
      card.load_pcard2 = 1'b0;
      card.load_pcard3 = 1'b0;
      card.load_dcard1 = 1'b0;
      card.load_dcard2 = 1'b0;
      card.load_dcard3 = 1'b0;
      busy             = 1'b0;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      player_wins      <= '0;
      dealer_wins      <= '0;
      ties             <= '0;
      rounds           <= '0;
    end else if (state_q == S_RESULT) begin
      player_win_light <= (card.pscore >= card.dscore);
      dealer_win_light <= (card.dscore >= card.pscore);
      if (card.pscore > card.dscore)      player_wins <= sat_inc(player_wins);
      else if (card.dscore > card.pscore) dealer_wins <= sat_inc(dealer_wins);
      else                                ties        <= sat_inc(ties);
      rounds <= sat_inc(rounds);
    end else if (restart) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baccarat_round_sched.sv
// Directed bench for baccarat_round_sched: table of hands plus stall, reset
// and saturation sequences; the bench plays the card/score datapath.
module tb_baccarat_round_sched;
  logic slow_clock = 1'b0;
  logic resetb, start;
  logic resetb_s, start_s;
  logic pl, dl, busy;
  logic [3:0] pw, dw, tw, rw;
  logic pl_s, dl_s, busy_s;
  logic [1:0] pw_s, dw_s, tw_s, rw_s;

  baccarat_round_sched_if cif();
  baccarat_round_sched_if sif();

  baccarat_round_sched #(.TW(4)) u_dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start), .card(cif),
    .player_win_light(pl), .dealer_win_light(dl),
    .player_wins(pw), .dealer_wins(dw), .ties(tw), .rounds(rw), .busy(busy)
  );

  baccarat_round_sched #(.TW(2)) u_sat (
    .slow_clock(slow_clock), .resetb(resetb_s), .start(start_s), .card(sif),
    .player_win_light(pl_s), .dealer_win_light(dl_s),
    .player_wins(pw_s), .dealer_wins(dw_s), .ties(tw_s), .rounds(rw_s), .busy(busy_s)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic [3:0] p2, d2, pc3, pf, df;
    int         stall;
    bit         exp_p3, exp_d3, exp_pl, exp_dl;
    int         exp_done;
  } vec_t;

  vec_t vecs[9];
  int nvec = 0;
  int nmis = 0;
  int e_pw = 0, e_dw = 0, e_tw = 0, e_rw = 0;

  function automatic vec_t mk(int p2, int d2, int pc3, int pf, int df, int stall,
                              bit p3, bit d3, bit epl, bit edl, int done_c);
    vec_t v;
    v.p2 = 4'(p2); v.d2 = 4'(d2); v.pc3 = 4'(pc3); v.pf = 4'(pf); v.df = 4'(df);
    v.stall = stall; v.exp_p3 = p3; v.exp_d3 = d3; v.exp_pl = epl; v.exp_dl = edl;
    v.exp_done = done_c;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_round(input vec_t v, input int idx);
    int cyc, ncard, stall_left, n_loads, n_dc1, done_cyc;
    bit saw_p3, saw_d3, clr, l_dc2, l_pc3, l_dc3;
    ncard = 0; stall_left = v.stall; n_loads = 0; n_dc1 = 0; done_cyc = -1;
    saw_p3 = 0; saw_d3 = 0;
    @(negedge slow_clock);
    start = 1'b1;
    cif.card_valid = 1'b1;
    @(posedge slow_clock);
    #1 start = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      @(negedge slow_clock);
      cif.card_valid = !(ncard == 1 && stall_left > 0);
      start = (cyc == 3);
      #1;
      if (!busy && cyc > 1) begin
        done_cyc = cyc;
        break;
      end
      if (cif.card_req && !cif.card_valid) stall_left--;
      n_loads += int'(cif.load_pcard1) + int'(cif.load_pcard2) + int'(cif.load_pcard3)
               + int'(cif.load_dcard1) + int'(cif.load_dcard2) + int'(cif.load_dcard3);
      if (cif.load_pcard1 | cif.load_pcard2 | cif.load_pcard3 |
          cif.load_dcard1 | cif.load_dcard2 | cif.load_dcard3) ncard++;
      n_dc1 += int'(cif.load_dcard1);
      saw_p3 |= cif.load_pcard3;
      saw_d3 |= cif.load_dcard3;
      clr = cif.clear_hands; l_dc2 = cif.load_dcard2;
      l_pc3 = cif.load_pcard3; l_dc3 = cif.load_dcard3;
      @(posedge slow_clock);
      #1;
      if (clr) begin cif.pscore = 4'd0; cif.dscore = 4'd0; cif.pcard3 = 4'd0; end
      if (l_dc2) begin cif.pscore = v.p2; cif.dscore = v.d2; end
      if (l_pc3) begin cif.pscore = v.pf; cif.pcard3 = v.pc3; end
      if (l_dc3) cif.dscore = v.df;
      cyc++;
    end
    start = 1'b0;
    if (v.exp_pl && !v.exp_dl) e_pw++;
    else if (v.exp_dl && !v.exp_pl) e_dw++;
    else e_tw++;
    e_rw++;
    chk($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done);
    chk($sformatf("v%0d p3_strobe", idx), int'(saw_p3), int'(v.exp_p3));
    chk($sformatf("v%0d d3_strobe", idx), int'(saw_d3), int'(v.exp_d3));
    chk($sformatf("v%0d load_count", idx), n_loads, 4 + int'(v.exp_p3) + int'(v.exp_d3));
    chk($sformatf("v%0d dcard1_count", idx), n_dc1, 1);
    chk($sformatf("v%0d player_light", idx), int'(pl), int'(v.exp_pl));
    chk($sformatf("v%0d dealer_light", idx), int'(dl), int'(v.exp_dl));
    chk($sformatf("v%0d player_wins", idx), int'(pw), e_pw);
    chk($sformatf("v%0d dealer_wins", idx), int'(dw), e_dw);
    chk($sformatf("v%0d ties", idx), int'(tw), e_tw);
    chk($sformatf("v%0d rounds", idx), int'(rw), e_rw);
  endtask

  initial begin
    int guard;
    // p2 d2 pc3 pf df stall | p3 d3 pl dl done
    vecs[0] = mk(8, 3, 0, 8, 3, 0, 0, 0, 1, 0, 8);   // player natural
    vecs[1] = mk(4, 3, 5, 9, 9, 0, 1, 1, 1, 1, 11);  // both draw, tie
    vecs[2] = mk(5, 6, 4, 2, 6, 0, 1, 0, 0, 1, 10);  // banker stands on 6 vs pcard3 4
    vecs[3] = mk(8, 3, 0, 8, 3, 3, 0, 0, 1, 0, 11);  // natural with D1 stalled 3 cycles
    vecs[4] = mk(6, 4, 0, 6, 7, 0, 0, 1, 0, 1, 9);   // player stands, banker draws
    vecs[5] = mk(7, 9, 0, 7, 9, 0, 0, 0, 0, 1, 8);   // dealer natural
    vecs[6] = mk(3, 3, 8, 1, 3, 0, 1, 0, 0, 1, 10);  // banker 3 stands on pcard3 8
    vecs[7] = mk(7, 7, 0, 7, 7, 0, 0, 0, 1, 1, 8);   // both stand, tie
    vecs[8] = mk(0, 7, 2, 2, 7, 0, 1, 0, 0, 1, 10);  // banker 7 never draws

    resetb = 1'b0; start = 1'b0; resetb_s = 1'b0; start_s = 1'b0;
    cif.card_valid = 1'b0; cif.pscore = 4'd0; cif.dscore = 4'd0; cif.pcard3 = 4'd0;
    sif.card_valid = 1'b1; sif.pscore = 4'd9; sif.dscore = 4'd0; sif.pcard3 = 4'd0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    chk("reset busy", int'(busy), 0);
    chk("reset card_req", int'(cif.card_req), 0);
    chk("reset lights", int'({pl, dl}), 0);
    chk("reset tallies", int'({pw, dw, tw, rw}), 0);
    resetb = 1'b1;
    @(negedge slow_clock);
    chk("idle holds without start", int'(busy), 0);

    for (int i = 0; i < 9; i++) run_round(vecs[i], i);

    // Abort a round in P2 with reset.
    @(negedge slow_clock);
    start = 1'b1; cif.card_valid = 1'b1;
    @(posedge slow_clock);
    #1 start = 1'b0;
    guard = 0;
    while (guard < 20) begin
      @(negedge slow_clock);
      #1;
      if (cif.load_pcard2) break;
      guard++;
    end
    chk("reach P2", int'(guard < 20), 1);
    resetb = 1'b0;
    #1;
    chk("reset cycle pcard2 strobe", int'(cif.load_pcard2), 0);
    chk("reset cycle card_req", int'(cif.card_req), 0);
    @(posedge slow_clock);
    #1 resetb = 1'b1;
    chk("abort busy", int'(busy), 0);
    chk("abort lights", int'({pl, dl}), 0);
    chk("abort tallies", int'({pw, dw, tw, rw}), 0);
    @(negedge slow_clock);
    chk("abort stays idle", int'(busy), 0);
    cif.card_valid = 1'b0;

    // TW=2 saturation with start held high through five back-to-back rounds.
    @(negedge slow_clock);
    resetb_s = 1'b1;
    start_s = 1'b1;
    repeat (37) @(negedge slow_clock);
    start_s = 1'b0;
    guard = 0;
    while (guard < 30 && busy_s) begin
      @(negedge slow_clock);
      guard++;
    end
    chk("sat ends idle", int'(busy_s), 0);
    chk("sat player_wins", int'(pw_s), 3);
    chk("sat rounds", int'(rw_s), 3);
    chk("sat dealer_wins", int'(dw_s), 0);
    chk("sat ties", int'(tw_s), 0);
    chk("sat lights", int'({pl_s, dl_s}), 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end
endmodule
